// File: rtl/sync_arith_unit_seq.sv
// rtl/sync_arith_unit_seq.sv - sequential arithmetic unit: shift, compare, restoring divide, sign-magnitude to two's complement
module sync_arith_unit_seq #(
    parameter int M  = 32,
    parameter int SW = $clog2(M)
) (
    input  logic         clk,
    input  logic         i_reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [M-1:0] iarg_A,
    input  logic [M-1:0] iarg_B,
    input  logic [3:0]   iop,
    output logic         o_valid,
    output logic [M-1:0] o_result,
    output logic [3:0]   o_status
);
    localparam logic [3:0]   OP_SHIFT = 4'b0000;
    localparam logic [3:0]   OP_CMP   = 4'b0001;
    localparam logic [3:0]   OP_DIV   = 4'b0010;
    localparam logic [3:0]   OP_ZM    = 4'b0011;
    localparam int           CW       = $clog2(M);
    localparam logic [M-1:0] M_VAL    = M'(M);

    typedef enum logic {S_IDLE, S_DIV} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [M-1:0]    rem_q, rem_d;
    logic [M-1:0]    quo_q, quo_d;
    logic [M-1:0]    dvs_q, dvs_d;
    logic            valid_q, valid_d;
    logic [M-1:0]    result_q, result_d;
    logic [3:0]      status_q, status_d;

    logic            accept, start_div, div_last;
    logic [M-1:0]    op_result;
    logic            op_err, op_ovf;
    logic [2*M-1:0]  shl_wide;
    logic            shift_big;
    logic [M:0]      rem_shl, trial;
    logic [M-1:0]    step_rem, step_quo;

    function automatic logic [3:0] pack_status(input logic [M-1:0] r, input logic err, input logic ovf);
        return {ovf, (r == '0), r[M-1], err};
    endfunction

    assign accept    = i_valid && o_ready;
    assign start_div = accept && (iop == OP_DIV) && (iarg_B != '0);
    assign div_last  = (state_q == S_DIV) && (cnt_q == CW'(M - 1));

    always_ff @(posedge clk) begin
        if (i_reset) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_div) state_d = S_DIV;
            S_DIV:   if (div_last)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state_q == S_IDLE);
    end

    // Single-cycle operations, evaluated straight from the request inputs.
    always_comb begin
        op_result = '0;
        op_err    = 1'b0;
        op_ovf    = 1'b0;
        shl_wide  = {{M{1'b0}}, iarg_A} << iarg_B[SW-1:0];
        shift_big = (iarg_B >= M_VAL);
        case (iop)
            OP_SHIFT: begin
                if (shift_big) begin
                    op_err = 1'b1;
                    op_ovf = (iarg_A != '0);
                end else begin
                    op_result = shl_wide[M-1:0];
                    op_ovf    = |shl_wide[2*M-1:M];
                end
            end
            OP_CMP: begin
                if ($signed(iarg_A) > $signed(iarg_B))      op_result = {{(M-1){1'b0}}, 1'b1};
                else if ($signed(iarg_A) < $signed(iarg_B)) op_result = '1;
            end
            OP_DIV: begin
                op_result = '1;
                op_err    = 1'b1;
            end
            OP_ZM: begin
                if (!iarg_A[M-1]) begin
                    op_result = iarg_A;
                end else begin
                    op_result = '0 - {1'b0, iarg_A[M-2:0]};
                    op_ovf    = (iarg_A[M-2:0] == '0);
                end
            end
            default: op_err = 1'b1;
        endcase
    end

    // One restoring step: quo_q doubles as the dividend shift register.
    always_comb begin
        rem_shl = {rem_q, quo_q[M-1]};
        trial   = rem_shl - {1'b0, dvs_q};
        if (trial[M]) begin
            step_rem = rem_shl[M-1:0];
            step_quo = {quo_q[M-2:0], 1'b0};
        end else begin
            step_rem = trial[M-1:0];
            step_quo = {quo_q[M-2:0], 1'b1};
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        valid_d  = 1'b0;
        result_d = result_q;
        status_d = status_q;
        if (state_q == S_DIV) begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + 1'b1;
            if (div_last) begin
                result_d = step_quo;
                status_d = pack_status(step_quo, 1'b0, 1'b0);
                valid_d  = 1'b1;
            end
        end else if (accept) begin
            if (start_div) begin
                cnt_d = '0;
                rem_d = '0;
                quo_d = iarg_A;
                dvs_d = iarg_B;
            end else begin
                result_d = op_result;
                status_d = pack_status(op_result, op_err, op_ovf);
                valid_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
            status_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            status_q <= status_d;
        end
    end

    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_status = status_q;
endmodule

// File: tb/tb_sync_arith_unit_seq.sv
// tb/tb_sync_arith_unit_seq.sv - scoreboard bench for sync_arith_unit_seq at M=32 and M=8
module tb_sync_arith_unit_seq;
    logic        clk;
    logic        rst;
    logic        v32, rdy32, val32;
    logic [31:0] a32, b32, res32;
    logic [3:0]  op32, st32;
    logic        v8, rdy8, val8;
    logic [7:0]  a8, b8, res8;
    logic [3:0]  op8, st8;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  st;
        int          cyc;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];

    sync_arith_unit_seq #(.M(32)) dut32 (
        .clk(clk), .i_reset(rst), .i_valid(v32), .o_ready(rdy32),
        .iarg_A(a32), .iarg_B(b32), .iop(op32),
        .o_valid(val32), .o_result(res32), .o_status(st32)
    );

    sync_arith_unit_seq #(.M(8)) dut8 (
        .clk(clk), .i_reset(rst), .i_valid(v8), .o_ready(rdy8),
        .iarg_A(a8), .iarg_B(b8), .iop(op8),
        .o_valid(val8), .o_result(res8), .o_status(st8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Independent reference for M=32: {OVF, ZERO, NEG, ERR, result}.
    function automatic logic [35:0] model32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        err, ovf;
        r = '0; err = 1'b0; ovf = 1'b0;
        case (op)
            4'd0: if (b >= 32'd32) begin err = 1'b1; ovf = (a != 0); end
                  else begin r = a << b[4:0]; ovf = ((r >> b[4:0]) != a); end
            4'd1: r = ($signed(a) > $signed(b)) ? 32'd1 : (a == b) ? 32'd0 : 32'hFFFF_FFFF;
            4'd2: if (b == 0) begin r = 32'hFFFF_FFFF; err = 1'b1; end else r = a / b;
            4'd3: if (!a[31]) r = a;
                  else begin r = 32'd0 - {1'b0, a[30:0]}; ovf = (a[30:0] == 0); end
            default: err = 1'b1;
        endcase
        return {ovf, (r == 0), r[31], err, r};
    endfunction

    always @(negedge clk) begin
        if (val32) begin
            check_eq("valid32_expected", 32'(q32.size() != 0), 32'd1);
            if (q32.size() != 0) begin
                exp_t e;
                e = q32.pop_front();
                check_eq("res32", res32, e.res);
                check_eq("status32", 32'(st32), 32'(e.st));
                check_eq("latency32", 32'(cyc), 32'(e.cyc));
            end
        end
        if (val8) begin
            check_eq("valid8_expected", 32'(q8.size() != 0), 32'd1);
            if (q8.size() != 0) begin
                exp_t e;
                e = q8.pop_front();
                check_eq("res8", 32'(res8), 32'(e.res[7:0]));
                check_eq("status8", 32'(st8), 32'(e.st));
                check_eq("latency8", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Drive at a negedge, push the expectation (lat < 0: none), advance one cycle.
    task automatic issue(input int w, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [3:0] es, input int lat);
        exp_t e;
        e.res = er; e.st = es; e.cyc = cyc + 1 + lat;
        if (w == 8) begin
            v32 = 1'b0; v8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
            if (lat >= 0) q8.push_back(e);
        end else begin
            v8 = 1'b0; v32 = 1'b1; op32 = op; a32 = a; b32 = b;
            if (lat >= 0) q32.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        v32 = 1'b0; v8 = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Count busy cycles while hammering the busy unit with requests it must ignore.
    task automatic wait_ready(input int w, input int exp_n);
        int n = 0;
        while (((w == 8) ? !rdy8 : !rdy32) && n < 200) begin
            n++;
            if (w == 8) begin v8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); op8 = 4'($urandom_range(0, 3)); end
            else begin v32 = 1'b1; a32 = $urandom; b32 = $urandom; op32 = 4'($urandom_range(0, 3)); end
            @(negedge clk);
        end
        v32 = 1'b0; v8 = 1'b0;
        check_eq("ready_low_cycles", 32'(n), 32'(exp_n));
    endtask

    task automatic do_reset(input bit with_req);
        rst = 1'b1;
        v32 = with_req; op32 = 4'd0; a32 = 32'd1; b32 = 32'd1;
        v8 = 1'b0;
        @(negedge clk);
        rst = 1'b0; v32 = 1'b0;
        check_eq("rst_ready32", 32'(rdy32), 32'd1);
        check_eq("rst_valid32", 32'(val32), 32'd0);
        check_eq("rst_result32", res32, 32'd0);
        check_eq("rst_status32", 32'(st32), 32'd0);
        check_eq("rst_ready8", 32'(rdy8), 32'd1);
        check_eq("rst_result8", 32'(res8), 32'd0);
    endtask

    task automatic issue_rand(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [35:0] m;
        int          lat;
        m   = model32(op, a, b);
        lat = (op == 4'd2 && b != 0) ? 32 : 0;
        issue(32, op, a, b, m[31:0], m[35:32], lat);
        if (lat > 0) wait_ready(32, 32);
    endtask

    initial begin
        rst = 1'b1; v32 = 1'b0; v8 = 1'b0;
        a32 = '0; b32 = '0; op32 = '0; a8 = '0; b8 = '0; op8 = '0;
        repeat (2) @(negedge clk);
        do_reset(1'b0);

        issue(32, 4'd0, 32'hA5A5_A5A5, 32'd4,          32'h5A5A_5A50, 4'b1000, 0);
        issue(32, 4'd1, 32'h0000_0001, 32'hFFFF_FFFF,  32'h0000_0001, 4'b0000, 0);
        issue(32, 4'd1, 32'h0000_0005, 32'h0000_0005,  32'h0000_0000, 4'b0100, 0);
        issue(32, 4'd0, 32'h0000_0001, 32'd32,         32'h0000_0000, 4'b1101, 0);
        issue(32, 4'd0, 32'h0000_0003, 32'd31,         32'h8000_0000, 4'b1010, 0);
        issue(32, 4'd3, 32'h8000_0001, 32'd0,          32'hFFFF_FFFF, 4'b0010, 0);
        issue(32, 4'd3, 32'h8000_0000, 32'd0,          32'h0000_0000, 4'b1100, 0);
        issue(32, 4'd3, 32'h7FFF_FFFF, 32'd0,          32'h7FFF_FFFF, 4'b0000, 0);
        issue(32, 4'd15, 32'h1234_5678, 32'd1,         32'h0000_0000, 4'b0101, 0);
        issue(32, 4'd2, 32'hFFFF_FFFF, 32'h0000_0001,  32'hFFFF_FFFF, 4'b0010, 32);
        wait_ready(32, 32);
        issue(32, 4'd2, 32'd9, 32'd0,                  32'hFFFF_FFFF, 4'b0011, 0);
        idle(3);

        issue(32, 4'd2, 32'd16, 32'd2, 32'd0, 4'b0000, -1);
        idle(9);
        do_reset(1'b1);
        idle(2);
        issue(32, 4'd2, 32'd16, 32'd2,                 32'd8, 4'b0000, 32);
        wait_ready(32, 32);

        issue(8, 4'd0, 32'h81, 32'd1,                  32'h02, 4'b1000, 0);
        issue(8, 4'd2, 32'hFF, 32'h10,                 32'h0F, 4'b0000, 8);
        wait_ready(8, 8);
        issue(8, 4'd7, 32'h55, 32'h01,                 32'h00, 4'b0101, 0);
        issue(8, 4'd0, 32'h01, 32'd8,                  32'h00, 4'b1101, 0);
        idle(2);

        for (int i = 0; i < 16; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'(i % 4);
            a  = $urandom;
            b  = (op == 4'd0) ? 32'($urandom_range(0, 40)) : $urandom;
            if (op == 4'd1 && i % 8 == 1) b = a;
            if (op == 4'd2 && i % 8 == 2) b = 32'($urandom_range(1, 300));
            issue_rand(op, a, b);
        end
        idle(1);

        for (int i = 0; i < 200 && (q32.size() != 0 || q8.size() != 0); i++) @(negedge clk);
        check_eq("drained32", 32'(q32.size()), 32'd0);
        check_eq("drained8", 32'(q8.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sync_arith_unit_seq.md
SYNC_ARITH_UNIT_SEQ -- requirements
Module: sync_arith_unit_seq

Interface
REQ-001 SHALL have parameter M, default 32, meaning operand/result width (legal M >= 4).
REQ-002 SHALL have parameter SW, default $clog2(M), meaning the shift-amount field width.
REQ-003 SHALL have port clk  input  1  meaning the single clock, with all state updated on its rising edge.
REQ-004 SHALL have port i_reset  input  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port i_valid  input  1  meaning an operation request is present.
REQ-006 SHALL have port o_ready  output  1  meaning the unit can accept a request.
REQ-007 SHALL have port iarg_A  input  M  meaning operand A.
REQ-008 SHALL have port iarg_B  input  M  meaning operand B.
REQ-009 SHALL have port iop  input  4  meaning the opcode: 0000 SHIFT, 0001 COMPARE, 0010 DIVIDE, 0011 ZM_TO_U2, others invalid.
REQ-010 SHALL have port o_valid  output  1  meaning a one-cycle result-completion pulse.
REQ-011 SHALL have port o_result  output  M  meaning the registered result.
REQ-012 SHALL have port o_status  output  4  meaning registered flags: [0] ERR, [1] NEG (= o_result[M-1]), [2] ZERO (o_result == 0), [3] OVF.

Function
REQ-013 SHALL accept a request on a rising edge where i_valid && o_ready && !i_reset, capturing iarg_A, iarg_B and iop.
REQ-014 SHALL implement FSM IDLE/DIV: IDLE->DIV on acceptance of a DIVIDE with iarg_B != 0; DIV->IDLE after M iterations; every other accept stays in IDLE.
REQ-015 SHALL drive o_ready = 1 in IDLE and 0 in DIV.
REQ-016 SHALL make non-iterative ops (SHIFT, COMPARE, ZM_TO_U2, divide-by-zero, invalid) write o_result/o_status on the accept edge and pulse o_valid for exactly the following cycle.
REQ-017 SHALL allow back-to-back non-iterative requests at one per cycle.
REQ-018 SHALL make SHIFT produce the logical left shift iarg_A << iarg_B[SW-1:0].
REQ-019 SHALL set OVF for SHIFT if any shifted-out bit is 1.
REQ-020 SHALL, for SHIFT with iarg_B >= M, return 0 with ERR=1, and set OVF if iarg_A != 0.
REQ-021 SHALL make COMPARE treat operands as two's complement and return 1 if A>B, all-ones if A<B, 0 if equal; OVF=0.
REQ-022 SHALL make DIVIDE perform unsigned restoring division, one quotient bit per cycle, MSB first, with o_result = quotient.
REQ-023 SHALL have DIVIDE pulse o_valid exactly M cycles after the accept edge, leaving the unit in IDLE that cycle.
REQ-024 SHALL, for DIVIDE with iarg_B == 0, return all-ones with ERR=1 and 1-cycle latency.
REQ-025 SHALL make ZM_TO_U2 treat iarg_A as sign-magnitude: bit M-1 = 0 gives A unchanged; otherwise -(A[M-2:0]) in M-bit two's complement.
REQ-026 SHALL convert negative zero (only bit M-1 set) to 0 with OVF=1.
REQ-027 SHALL make invalid opcodes return 0 with ERR=1.
REQ-028 SHALL ignore i_valid while o_ready = 0 (no queueing) and SHALL leave in-flight operands unaffected by input changes.
REQ-029 SHALL hold o_result and o_status between completions; o_valid SHALL be 0 whenever no completion occurs.
REQ-030 SHALL perform all arithmetic at width M with no truncation beyond what is stated above.

Reset
REQ-031 SHALL, on any rising edge with i_reset = 1, set the FSM to IDLE, o_ready=1, o_valid=0, o_result=0, o_status=0, and clear the iteration counter and divider registers.
REQ-032 SHALL make reset during DIV abort the division with no o_valid pulse for it.
REQ-033 SHALL give reset priority over a simultaneous request, which SHALL be dropped.

Verification
REQ-034 SHALL verify: SHIFT A=0xA5A5A5A5, B=4 -> 0x5A5A5A50, OVF=1, ERR=0, NEG=0, o_valid one cycle after accept.
REQ-035 SHALL verify: COMPARE A=0x00000001, B=0xFFFFFFFF -> 0x00000001; then A=B=0x00000005 -> 0, ZERO=1.
REQ-036 SHALL verify: DIVIDE 0xFFFFFFFF/0x00000001 -> 0xFFFFFFFF, NEG=1, o_ready low exactly 32 cycles, o_valid on the 32nd; then 9/0 -> 0xFFFFFFFF, ERR=1, 1-cycle latency.
REQ-037 SHALL verify: ZM_TO_U2 A=0x80000001 -> 0xFFFFFFFF, NEG=1; A=0x80000000 -> 0, ZERO=1, OVF=1; A=0x7FFFFFFF -> 0x7FFFFFFF.
REQ-038 SHALL verify: accept DIVIDE 16/2, assert i_reset 10 cycles later -> no o_valid, all outputs 0, o_ready=1; then DIVIDE 16/2 -> 8 after 32 cycles.
REQ-039 SHALL verify: with M=8, SHIFT A=0x81, B=1 -> 0x02, OVF=1; DIVIDE 0xFF/0x10 -> 0x0F after 8 cycles; opcode 0111 -> 0, ERR=1.
